// File: rtl/memxfer_pkg.sv
// Shared definitions for the memxfer core: mode and state encodings, config
// field positions and status/interrupt bit indices.
package memxfer_pkg;

    typedef enum logic [1:0] {
        MODE_COPY = 2'b00,
        MODE_ADD  = 2'b01,
        MODE_ACC  = 2'b10,
        MODE_REV  = 2'b11
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE,
        ST_ERR
    } state_e;

    localparam int CFG_N_LSB    = 0;
    localparam int CFG_N_W      = 16;
    localparam int CFG_MODE_LSB = 16;
    localparam int CFG_MODE_W   = 2;
    localparam int CNT_W        = CFG_N_W;

    localparam int STAT_BUSY = 0;
    localparam int STAT_OVF  = 1;
    localparam int INT_DONE  = 0;
    localparam int INT_ERR   = 1;

    // Source index for output position i; reverse mode walks the input backwards.
    function automatic logic [CNT_W-1:0] read_index(input logic [CNT_W-1:0] n,
                                                    input mode_e mode,
                                                    input logic [CNT_W-1:0] i);
        return (mode == MODE_REV) ? (n - CNT_W'(1) - i) : i;
    endfunction

endpackage

// File: rtl/memxfer_ctrl.sv
// Job sequencer for memxfer: FSM, read index counter, read address generation
// and the one-entry hold register that keeps in-flight read data across a stall.
module memxfer_ctrl
    import memxfer_pkg::*;
#(
    parameter int AW_I = 6,
    parameter int AW_O = 6,
    parameter int DW   = 32
) (
    input  logic             clk,
    input  logic             rst_a,
    input  logic             en_s,
    input  logic             start,
    input  logic [CNT_W-1:0] cfg_n,
    input  mode_e            cfg_mode,
    input  logic [DW-1:0]    cfg_k,
    input  logic [DW-1:0]    data_in,
    output logic [AW_I-1:0]  rd_addr,
    output logic [DW-1:0]    rd_data,
    output logic             wr_valid,
    output mode_e            mode,
    output logic [DW-1:0]    k,
    output logic             job_start,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [31:0] DEPTH_I = 32'(1) << AW_I;
    localparam logic [31:0] DEPTH_O = 32'(1) << AW_O;

    state_e           state_reg;
    logic [CNT_W-1:0] n_reg;
    mode_e            mode_reg;
    logic [DW-1:0]    k_reg;
    logic [CNT_W-1:0] idx_reg;
    logic [AW_I-1:0]  rd_addr_reg;
    logic             rd_valid_reg;
    logic             data_valid_reg;
    logic [DW-1:0]    hold_data_reg;
    logic             hold_valid_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             err_reg;

    logic             cfg_ok;
    logic [AW_I-1:0]  rd_addr_next;

    assign cfg_ok = (cfg_n != '0) && (32'(cfg_n) <= DEPTH_I) && (32'(cfg_n) <= DEPTH_O);

    // The first read is issued in the same edge that accepts the job, so IDLE
    // addresses from the live config rather than the latched copy.
    always_comb begin
        rd_addr_next = '0;
        if (state_reg == ST_IDLE)
            rd_addr_next = AW_I'(read_index(cfg_n, cfg_mode, '0));
        else
            rd_addr_next = AW_I'(read_index(n_reg, mode_reg, idx_reg));
    end

    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            state_reg      <= ST_IDLE;
            n_reg          <= '0;
            mode_reg       <= MODE_COPY;
            k_reg          <= '0;
            idx_reg        <= '0;
            rd_addr_reg    <= '0;
            rd_valid_reg   <= 1'b0;
            data_valid_reg <= 1'b0;
            hold_data_reg  <= '0;
            hold_valid_reg <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
        end else if (!en_s) begin
            // The RAM keeps following the held address, so grab the word it is
            // presenting now before it is overwritten on the next edge.
            if (!hold_valid_reg) begin
                hold_data_reg  <= data_in;
                hold_valid_reg <= 1'b1;
            end
        end else begin
            hold_valid_reg <= 1'b0;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
            data_valid_reg <= rd_valid_reg;
            rd_valid_reg   <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        n_reg    <= cfg_n;
                        mode_reg <= cfg_mode;
                        k_reg    <= cfg_k;
                        if (cfg_ok) begin
                            state_reg    <= ST_RUN;
                            busy_reg     <= 1'b1;
                            rd_addr_reg  <= rd_addr_next;
                            rd_valid_reg <= 1'b1;
                            idx_reg      <= CNT_W'(1);
                        end else begin
                            state_reg <= ST_ERR;
                            err_reg   <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (idx_reg == n_reg) begin
                        state_reg <= ST_DRAIN;
                    end else begin
                        rd_addr_reg  <= rd_addr_next;
                        rd_valid_reg <= 1'b1;
                        idx_reg      <= idx_reg + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (!rd_valid_reg && !data_valid_reg) begin
                        state_reg <= ST_DONE;
                        done_reg  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
                ST_ERR:  state_reg <= ST_IDLE;
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign rd_addr   = rd_addr_reg;
    assign rd_data   = hold_valid_reg ? hold_data_reg : data_in;
    assign wr_valid  = data_valid_reg;
    assign mode      = mode_reg;
    assign k         = k_reg;
    assign job_start = en_s && (state_reg == ST_IDLE) && start && cfg_ok;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign err       = err_reg;

endmodule

// File: rtl/memxfer_core.sv
// memxfer top: per-job transform of input memory 0 into output memory 0.
// Holds the write-stage arithmetic, sticky overflow and the output registers.
module memxfer_core
    import memxfer_pkg::*;
#(
    parameter int ADDR_WIDTH_MEMI = 6,
    parameter int ADDR_WIDTH_MEMO = 6,
    parameter int DATA_WIDTH      = 32,
    parameter int SIZE_CR         = 2
) (
    input  logic                          clk,
    input  logic                          rst_a,
    input  logic                          en_s,
    input  logic                          start_IPcore,
    input  logic [DATA_WIDTH-1:0]         data_MemIn0,
    output logic [ADDR_WIDTH_MEMI-1:0]    rd_addr_MemIn0,
    input  logic [SIZE_CR*DATA_WIDTH-1:0] data_ConfigReg,
    output logic [DATA_WIDTH-1:0]         data_MemOut0,
    output logic [ADDR_WIDTH_MEMO-1:0]    wr_addr_MemOut0,
    output logic                          wr_en_MemOut0,
    output logic [7:0]                    status_IPcore,
    output logic [7:0]                    int_IPcore
);

    logic [DATA_WIDTH-1:0] cfg_word0;
    logic [CNT_W-1:0]      cfg_n;
    mode_e                 cfg_mode;
    logic [DATA_WIDTH-1:0] cfg_k;
    logic                  unused_cfg;

    assign cfg_word0  = data_ConfigReg[DATA_WIDTH-1:0];
    assign cfg_n      = cfg_word0[CFG_N_LSB +: CFG_N_W];
    assign cfg_mode   = mode_e'(cfg_word0[CFG_MODE_LSB +: CFG_MODE_W]);
    assign cfg_k      = data_ConfigReg[DATA_WIDTH +: DATA_WIDTH];
    assign unused_cfg = ^cfg_word0[DATA_WIDTH-1:CFG_MODE_LSB+CFG_MODE_W];

    logic [DATA_WIDTH-1:0] rd_data;
    logic                  wr_valid;
    mode_e                 mode;
    logic [DATA_WIDTH-1:0] k;
    logic                  job_start;
    logic                  busy;
    logic                  done;
    logic                  err;

    memxfer_ctrl #(
        .AW_I (ADDR_WIDTH_MEMI),
        .AW_O (ADDR_WIDTH_MEMO),
        .DW   (DATA_WIDTH)
    ) u_ctrl (
        .clk       (clk),
        .rst_a     (rst_a),
        .en_s      (en_s),
        .start     (start_IPcore),
        .cfg_n     (cfg_n),
        .cfg_mode  (cfg_mode),
        .cfg_k     (cfg_k),
        .data_in   (data_MemIn0),
        .rd_addr   (rd_addr_MemIn0),
        .rd_data   (rd_data),
        .wr_valid  (wr_valid),
        .mode      (mode),
        .k         (k),
        .job_start (job_start),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    logic [DATA_WIDTH-1:0]      data_reg;
    logic [ADDR_WIDTH_MEMO-1:0] wr_addr_reg;
    logic                       wr_en_reg;
    logic [ADDR_WIDTH_MEMO-1:0] wr_cnt_reg;
    logic [DATA_WIDTH-1:0]      acc_reg;
    logic                       ovf_reg;
    logic [DATA_WIDTH:0]        result;

    // One extra bit on the sum carries the overflow out of add and running-sum.
    always_comb begin
        result = {1'b0, rd_data};
        case (mode)
            MODE_ADD: result = {1'b0, rd_data} + {1'b0, k};
            MODE_ACC: result = {1'b0, acc_reg} + {1'b0, rd_data};
            default:  result = {1'b0, rd_data};
        endcase
    end

    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            data_reg    <= '0;
            wr_addr_reg <= '0;
            wr_en_reg   <= 1'b0;
            wr_cnt_reg  <= '0;
            acc_reg     <= '0;
            ovf_reg     <= 1'b0;
        end else if (en_s) begin
            wr_en_reg <= wr_valid;
            if (job_start) begin
                ovf_reg    <= 1'b0;
                acc_reg    <= '0;
                wr_cnt_reg <= '0;
            end else if (wr_valid) begin
                data_reg    <= result[DATA_WIDTH-1:0];
                wr_addr_reg <= wr_cnt_reg;
                wr_cnt_reg  <= wr_cnt_reg + 1'b1;
                acc_reg     <= result[DATA_WIDTH-1:0];
                if (result[DATA_WIDTH])
                    ovf_reg <= 1'b1;
            end
        end
    end

    logic [7:0] status_next;
    logic [7:0] int_next;

    always_comb begin
        status_next            = '0;
        status_next[STAT_BUSY] = busy;
        status_next[STAT_OVF]  = ovf_reg;
        int_next               = '0;
        int_next[INT_DONE]     = done;
        int_next[INT_ERR]      = err;
    end

    // Pulses stay pending in their registers during a stall and appear on resume.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_int
            assign int_IPcore[gi] = int_next[gi] & en_s;
        end
    endgenerate

    assign status_IPcore   = status_next;
    assign data_MemOut0    = data_reg;
    assign wr_addr_MemOut0 = wr_addr_reg;
    assign wr_en_MemOut0   = wr_en_reg & en_s;

endmodule

// File: tb/tb_memxfer_core.sv
// Self-checking bench for memxfer_core: timeline model of each job plus
// hand-computed memory and timing expectations.
module tb_memxfer_core;

    localparam int AWI = 6;
    localparam int AWO = 6;
    localparam int DW  = 32;
    localparam int DI  = 64;
    localparam logic [31:0] SENT = 32'hDEAD_BEEF;

    logic          clk = 1'b0;
    logic          rst_a;
    logic          en_s;
    logic          start_IPcore;
    logic [DW-1:0] data_MemIn0;
    logic [AWI-1:0] rd_addr_MemIn0;
    logic [2*DW-1:0] data_ConfigReg;
    logic [DW-1:0] data_MemOut0;
    logic [AWO-1:0] wr_addr_MemOut0;
    logic          wr_en_MemOut0;
    logic [7:0]    status_IPcore;
    logic [7:0]    int_IPcore;

    always #5 clk = ~clk;

    memxfer_core #(
        .ADDR_WIDTH_MEMI (AWI),
        .ADDR_WIDTH_MEMO (AWO),
        .DATA_WIDTH      (DW),
        .SIZE_CR         (2)
    ) dut (
        .clk             (clk),
        .rst_a           (rst_a),
        .en_s            (en_s),
        .start_IPcore    (start_IPcore),
        .data_MemIn0     (data_MemIn0),
        .rd_addr_MemIn0  (rd_addr_MemIn0),
        .data_ConfigReg  (data_ConfigReg),
        .data_MemOut0    (data_MemOut0),
        .wr_addr_MemOut0 (wr_addr_MemOut0),
        .wr_en_MemOut0   (wr_en_MemOut0),
        .status_IPcore   (status_IPcore),
        .int_IPcore      (int_IPcore)
    );

    logic [31:0] mem_in  [0:DI-1];
    logic [31:0] mem_out [0:DI-1];
    int wr_count;

    // Synchronous RAMs around the core.
    initial forever begin
        @(posedge clk);
        data_MemIn0 <= mem_in[rd_addr_MemIn0];
        if (wr_en_MemOut0) begin
            mem_out[wr_addr_MemOut0] <= data_MemOut0;
            wr_count++;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Job model: L counts enabled edges since the accepting edge.
    int          cyc = 0;
    bit          active = 0;
    bit          is_err = 0;
    int          L = 0;
    int          n_job = 0;
    int          mode_j = 0;
    int          start_cyc = 0;
    bit          ovf_final = 0;
    logic [31:0] exp_out [0:DI-1];

    task automatic accept_job();
        logic [31:0] k_j;
        logic [31:0] acc;
        logic [32:0] s;
        bit          ov;
        n_job     = int'(data_ConfigReg[15:0]);
        mode_j    = int'(data_ConfigReg[17:16]);
        k_j       = data_ConfigReg[63:32];
        is_err    = (n_job == 0) || (n_job > DI);
        start_cyc = cyc;
        L         = 1;
        active    = 1;
        if (!is_err) begin
            acc = 0;
            ov  = 0;
            for (int i = 0; i < n_job; i++) begin
                case (mode_j)
                    0: exp_out[i] = mem_in[i];
                    1: begin
                        s = {1'b0, mem_in[i]} + {1'b0, k_j};
                        exp_out[i] = s[31:0];
                        ov = ov | s[32];
                    end
                    2: begin
                        s = {1'b0, acc} + {1'b0, mem_in[i]};
                        exp_out[i] = s[31:0];
                        acc = s[31:0];
                        ov = ov | s[32];
                    end
                    default: exp_out[i] = mem_in[n_job-1-i];
                endcase
            end
            ovf_final = ov;
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
        if (rst_a) begin
            active    = 0;
            ovf_final = 0;
        end else if (!active) begin
            if (start_IPcore && en_s)
                accept_job();
        end else if (en_s) begin
            L++;
            if (is_err ? (L > 1) : (L > n_job + 3))
                active = 0;
        end
    end

    function automatic int exp_rd(input int i);
        return (mode_j == 3) ? (n_job - 1 - i) : i;
    endfunction

    int done_rel, err_rel, first_wr_rel, last_wr_rel;

    // Per-cycle compare against the job model.
    initial forever begin
        bit job, exp_wr, exp_done, exp_err;
        int rel;
        @(negedge clk);
        if (rst_a) begin
            chk("rst_wr_en", wr_en_MemOut0, 0);
            chk("rst_rd_addr", rd_addr_MemIn0, 0);
            chk("rst_wr_addr", wr_addr_MemOut0, 0);
            chk("rst_data", data_MemOut0, 0);
            chk("rst_status", status_IPcore, 0);
            chk("rst_int", int_IPcore, 0);
        end else begin
            job      = active && !is_err;
            exp_wr   = job && en_s && (L >= 3) && (L <= n_job + 2);
            exp_done = job && en_s && (L == n_job + 3);
            exp_err  = active && is_err && en_s;
            chk("wr_en", wr_en_MemOut0, exp_wr);
            chk("busy", status_IPcore[0], job);
            chk("status_hi", status_IPcore[7:2], 0);
            chk("int", int_IPcore, {6'b0, exp_err, exp_done});
            if (exp_wr) begin
                chk("wr_addr", wr_addr_MemOut0, L - 3);
                chk("wr_data", data_MemOut0, exp_out[L-3]);
            end
            if (job && L <= n_job)
                chk("rd_addr", rd_addr_MemIn0, exp_rd(L - 1));
            if (!job || L >= n_job + 3)
                chk("ovf", status_IPcore[1], ovf_final);
            else if (L == 1)
                chk("ovf_clear", status_IPcore[1], 0);
            rel = cyc - start_cyc + 1;
            if (int_IPcore[0]) done_rel = rel;
            if (int_IPcore[1]) err_rel = rel;
            if (wr_en_MemOut0) begin
                if (first_wr_rel == 0) first_wr_rel = rel;
                last_wr_rel = rel;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_job(input int n, input int mode, input logic [31:0] k);
        logic [15:0] nb;
        logic [1:0]  mb;
        nb = 16'(n);
        mb = 2'(mode);
        for (int i = 0; i < DI; i++) mem_out[i] = SENT;
        wr_count     = 0;
        done_rel     = 0;
        err_rel      = 0;
        first_wr_rel = 0;
        last_wr_rel  = 0;
        data_ConfigReg = {k, 14'b0, mb, nb};
        start_IPcore = 1'b1;
        tick();
        start_IPcore = 1'b0;
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 300 && active; c++) tick();
        chk("job_timeout", active, 0);
        tick();
    endtask

    task automatic load3(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        mem_in[0] = a;
        mem_in[1] = b;
        mem_in[2] = c;
    endtask

    initial begin
        rst_a = 1'b1;
        en_s = 1'b1;
        start_IPcore = 1'b0;
        data_ConfigReg = '0;
        wr_count = 0;
        for (int i = 0; i < DI; i++) begin
            mem_in[i]  = 32'(i * 3 + 7);
            mem_out[i] = SENT;
            exp_out[i] = '0;
        end
        repeat (3) tick();
        rst_a = 1'b0;
        tick();

        // Copy N=4
        mem_in[3] = 4;
        load3(1, 2, 3);
        begin_job(4, 0, 0);
        wait_idle();
        chk("copy_out0", mem_out[0], 1);
        chk("copy_out3", mem_out[3], 4);
        chk("copy_out4_untouched", mem_out[4], SENT);
        chk("copy_first_wr", first_wr_rel, 3);
        chk("copy_last_wr", last_wr_rel, 6);
        chk("copy_done", done_rel, 7);
        chk("copy_ovf", status_IPcore[1], 0);

        // Add with wrap
        mem_in[0] = 32'hFFFF_FFFF;
        mem_in[1] = 5;
        begin_job(2, 1, 2);
        wait_idle();
        chk("add_out0", mem_out[0], 1);
        chk("add_out1", mem_out[1], 7);
        chk("add_ovf", status_IPcore[1], 1);

        // Running sum, with an ignored start while busy
        load3(1, 2, 3);
        begin_job(3, 2, 0);
        data_ConfigReg = '0;
        start_IPcore = 1'b1;
        tick();
        start_IPcore = 1'b0;
        wait_idle();
        chk("acc_out0", mem_out[0], 1);
        chk("acc_out1", mem_out[1], 3);
        chk("acc_out2", mem_out[2], 6);
        chk("acc_ovf_cleared", status_IPcore[1], 0);
        chk("acc_no_err", err_rel, 0);

        // Reverse
        begin_job(3, 3, 0);
        wait_idle();
        chk("rev_out0", mem_out[0], 3);
        chk("rev_out1", mem_out[1], 2);
        chk("rev_out2", mem_out[2], 1);

        // Rejected starts
        begin_job(0, 0, 0);
        wait_idle();
        chk("err0_pulse", err_rel, 1);
        chk("err0_writes", wr_count, 0);
        chk("err0_done", done_rel, 0);
        begin_job(DI + 1, 0, 0);
        wait_idle();
        chk("errbig_pulse", err_rel, 1);
        chk("errbig_writes", wr_count, 0);

        // Stall for 3 cycles after the second write
        mem_in[0] = 10; mem_in[1] = 20; mem_in[2] = 30; mem_in[3] = 40;
        begin_job(4, 0, 0);
        repeat (4) tick();
        en_s = 1'b0;
        repeat (3) tick();
        en_s = 1'b1;
        wait_idle();
        chk("stall_out0", mem_out[0], 10);
        chk("stall_out2", mem_out[2], 30);
        chk("stall_out3", mem_out[3], 40);
        chk("stall_writes", wr_count, 4);
        chk("stall_done", done_rel, 10);

        // Reset in cycle 4 of an N=8 job, then an N=1 job
        for (int i = 0; i < 8; i++) mem_in[i] = 32'(100 + i);
        begin_job(8, 0, 0);
        repeat (3) tick();
        rst_a = 1'b1;
        repeat (2) tick();
        rst_a = 1'b0;
        tick();
        chk("rst_partial0", mem_out[0], 100);
        chk("rst_partial1", mem_out[1], SENT);
        chk("rst_no_done", done_rel, 0);
        begin_job(1, 0, 0);
        wait_idle();
        chk("post_rst_out0", mem_out[0], 100);
        chk("post_rst_done", done_rel, 4);

        // Full-depth job
        for (int i = 0; i < DI; i++) mem_in[i] = 32'(i * 5 + 1);
        begin_job(DI, 0, 0);
        wait_idle();
        chk("full_writes", wr_count, DI);
        chk("full_out63", mem_out[63], 316);
        chk("full_done", done_rel, DI + 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/memxfer_core.md
# memxfer_core

Parametrised successor to the single-channel dummy IP core. Reads N words from input memory 0, applies a per-job transform (copy, add-constant, running sum, reverse), and writes the results to output memory 0. Sits behind the IP-core wrapper and is driven by start/config/status/interrupt signals. Adds the following over the dummy core: job length, four modes, sticky overflow, error interrupt, and a stall-safe read pipeline.

## Interface
- ADDR_WIDTH_MEMI, 6, input memory address width; depth DI = 2^ADDR_WIDTH_MEMI
- ADDR_WIDTH_MEMO, 6, output memory address width; depth DO = 2^ADDR_WIDTH_MEMO
- DATA_WIDTH, 32, word width
- SIZE_CR, 2, config words; fixed at 2
- clk  in  1  clock; one clock, all logic on rising edge
- rst_a  in  1  reset; asynchronous, active-high
- en_s  in  1  synchronous enable; low = full stall
- start_IPcore  in  1  job start pulse
- data_MemIn0  in  DATA_WIDTH  read data from a synchronous RAM, valid 1 cycle after the address
- rd_addr_MemIn0  out  ADDR_WIDTH_MEMI  read address
- data_ConfigReg  in  SIZE_CR*DATA_WIDTH  word0 [15:0] = N, word0 [17:16] = MODE, word1 = K
- data_MemOut0  out  DATA_WIDTH  write data, registered
- wr_addr_MemOut0  out  ADDR_WIDTH_MEMO  write address, registered
- wr_en_MemOut0  out  1  write strobe, registered
- status_IPcore  out  8  bit0 busy, bit1 ovf (sticky), others 0
- int_IPcore  out  8  bit0 done pulse, bit1 err pulse, others 0

## Operation
- Reset value of every output is 0, and all internal registers clear.
- State machine: IDLE -> RUN -> DRAIN -> DONE -> IDLE; ERR is a one-cycle state -> IDLE.
- IDLE with start_IPcore=1 and en_s=1: latch N, MODE and K.
  - If N=0, N>DI or N>DO: go to ERR. ERR pulses err and performs no reads or writes.
  - Otherwise: go to RUN and clear ovf.
- start_IPcore is ignored outside IDLE.
- RUN issues read index i = 0..N-1, one per enabled cycle.
  - rd_addr = i, or N-1-i when MODE=11.
  - After the last issue, go to DRAIN.
- Write stage: the word for index i is written at wr_addr = i.
  - MODE 00 copy: out = in.
  - MODE 01 add: out = in + K, mod 2^DATA_WIDTH; a carry-out sets ovf.
  - MODE 10 running sum: acc starts at 0 per job; out = acc + in; acc <= out; a carry-out sets ovf.
  - MODE 11 reverse: out = in[N-1-i].
- DRAIN: wait until the last write has been registered, then go to DONE.
- DONE: pulse done for one cycle, then go to IDLE.
- busy = 1 in RUN, DRAIN and DONE.
- ovf stays valid after the job and is cleared only by the next accepted start or by reset.
- en_s=0 freezes all state: FSM, counters, acc, and output registers.
  - wr_en_MemOut0 is forced to 0 while en_s=0.
  - rd_addr holds its value.
  - A one-entry hold register captures the in-flight data_MemIn0 in the first stalled cycle. On resume, the write stage uses the held word, then returns to live data.
- rst_a asserted mid-job: immediate return to IDLE, outputs 0, no done pulse, the partial output-memory contents are left as-is.

## Timing
- Start sampled at edge 0.
- Reads: rd_addr presented in cycles 1..N.
- Data: arrives in cycles 2..N+1.
- Writes: wr_en high in cycles 3..N+2, one per cycle, no gaps when en_s=1.
- done: pulses in cycle N+3; busy is high in cycles 1..N+3.
- err: pulses in cycle 1 after a rejected start; busy stays 0.
- Each stall cycle adds exactly one cycle to every later event.
- int bits are single-cycle pulses and are never asserted while en_s=0. A pending pulse is emitted on resume.
- A new start is accepted in the cycle after DONE (cycle N+4).

## Structure
- The shared package holds:
  - MODE encodings: MODE_COPY, MODE_ADD, MODE_ACC, MODE_REV
  - FSM state enum
  - config-field bit positions
  - status/int bit indices
- Sub-module memxfer_ctrl: FSM, index counter, address generation, hold register.
- The top-level holds the data-path arithmetic and the output registers.

## Test plan
- Copy: MODE=00, N=4, in = {1,2,3,4} -> out[0..3] = {1,2,3,4}; wr_en in cycles 3..6; done in cycle 7; ovf=0.
- Add with wrap: MODE=01, K=2, N=2, in = {0xFFFFFFFF, 5} -> out = {1, 7}; ovf=1 after done.
- Running sum and reverse:
  - MODE=10, in = {1,2,3} -> out = {1,3,6}.
  - MODE=11, in = {1,2,3} -> out = {3,2,1}.
- Errors and ignored starts:
  - N=0 -> err pulse in cycle 1, no wr_en, busy stays 0.
  - N=DI+1 -> same result.
  - A start during busy is ignored.
- Stall: en_s low for 3 cycles after the 2nd write of an N=4 copy -> identical memory contents; done in cycle 10; no wr_en while en_s=0.
- Reset mid-job: rst_a asserted in cycle 4 of N=8 -> all outputs 0 immediately, no done pulse; a subsequent N=1 job completes normally.
